tt_bist_harness: RTL and testbench

- Synthesizable built-in self-test harness for the TinyTapeout user-project interface.
- Drives a DUT's dedicated inputs from a selectable stimulus source: external pass-through, counter, or LFSR.
- Compacts the DUT's enabled outputs into a MISR signature.
- Sits between the pad-facing ui_in/uo_out and a user core, so silicon can be checked without an external tester. It generalises the fixed 8-bit single-project hookup to parametrised widths and stimulus modes.

---
 rtl/tt_bist_pkg.sv | 46 ++++
 rtl/tt_bist_harness_misr.sv | 43 ++++
 rtl/tt_bist_harness.sv | 148 ++++++++++++++
 tb/tb_tt_bist_harness.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tt_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_bist_pkg
// Description : Shared types, mode codes and LFSR/MISR step functions for the
//               TinyTapeout BIST harness.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_bist_pkg;

  localparam int SIG_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_CNT  = 2'b01;
  localparam logic [1:0] MODE_LFSR = 2'b10;

  // Galois step on the low w bits of a SIG_MAX-wide container.
  function automatic logic [SIG_MAX-1:0] lfsr_step(
    input logic [SIG_MAX-1:0] v,
    input logic [SIG_MAX-1:0] poly,
    input int                 w
  );
    logic [SIG_MAX-1:0] mask;
    logic               msb;
    mask = (SIG_MAX'(1) << w) - SIG_MAX'(1);
    msb  = |(v & (SIG_MAX'(1) << (w - 1)));
    return ((v << 1) ^ (msb ? poly : '0)) & mask;
  endfunction

  function automatic logic [SIG_MAX-1:0] misr_step(
    input logic [SIG_MAX-1:0] v,
    input logic [SIG_MAX-1:0] poly,
    input logic [SIG_MAX-1:0] data,
    input int                 w
  );
    return lfsr_step(v, poly, w) ^ data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tt_bist_harness_misr.sv
`default_nettype none
// ============================================================================
// Module      : tt_bist_misr
// Description : Multiple-input signature register with clear, enable and
//               per-bit data mask; reusable for any output bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_bist_misr
  import tt_bist_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter int               OUT_W = 8,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(16'h1021)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [OUT_W-1:0] i_data,
  input  logic [OUT_W-1:0] i_mask,
  output logic [SIG_W-1:0] o_sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_sig_next;

  assign w_sig_next = SIG_W'(misr_step(SIG_MAX'(r_sig), SIG_MAX'(POLY),
                                       SIG_MAX'(i_data & i_mask), SIG_W));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (i_clr) begin
      r_sig <= '0;
    end else if (i_en) begin
      r_sig <= w_sig_next;
    end
  end

  assign o_sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/tt_bist_harness.sv
`default_nettype none
// ============================================================================
// Module      : tt_bist_harness
// Description : BIST harness: drives DUT inputs from pass-through, counter or
//               LFSR stimulus and compacts masked DUT outputs into a MISR.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_bist_harness
  import tt_bist_pkg::*;
#(
  parameter int               IN_W     = 8,
  parameter int               OUT_W    = 8,
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] POLY     = SIG_W'(16'h1021),
  parameter logic [SIG_W-1:0] SEED     = SIG_W'(16'hACE1),
  parameter int               PIPE_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [7:0]       n_vec,
  input  logic [IN_W-1:0]  ext_in,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  input  logic [OUT_W-1:0] dut_oe,
  output logic [SIG_W-1:0] signature,
  output logic             busy,
  output logic             done
);

  localparam int DEPTH = PIPE_LAT + 1;

  state_t           r_state;
  logic [1:0]       r_mode;
  logic [7:0]       r_nvec;
  logic [7:0]       r_vec_cnt;
  logic [IN_W-1:0]  r_cnt;
  logic [IN_W-1:0]  r_dut_in;
  logic [SIG_W-1:0] r_lfsr;
  logic [DEPTH-1:0] r_vld;
  logic             r_busy;
  logic             r_done;

  logic             w_start_ok;
  logic             w_issue;
  logic             w_last;
  logic             w_cap;
  logic [DEPTH-1:0] w_vld_next;
  logic [SIG_W-1:0] w_lfsr_next;
  logic [IN_W-1:0]  w_src;

  assign w_start_ok  = ena & start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_issue     = (r_state == ST_RUN);
  // n_vec of 0 wraps to a last index of 255, giving 256 vectors.
  assign w_last      = (r_vec_cnt == (r_nvec - 8'd1));
  assign w_vld_next  = DEPTH'({r_vld, w_issue});
  assign w_cap       = ena & r_vld[DEPTH-1];
  assign w_lfsr_next = SIG_W'(lfsr_step(SIG_MAX'(r_lfsr), SIG_MAX'(POLY), SIG_W));

  always_comb begin
    w_src = ext_in;
    case (r_mode)
      MODE_CNT:  w_src = r_cnt;
      MODE_LFSR: w_src = r_lfsr[IN_W-1:0];
      default:   w_src = ext_in;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_PASS;
      r_nvec    <= 8'd0;
      r_vec_cnt <= 8'd0;
      r_cnt     <= '0;
      r_dut_in  <= '0;
      r_lfsr    <= SEED;
      r_vld     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (ena) begin
      r_vld <= w_vld_next;
      if (w_start_ok) begin
        r_mode    <= mode;
        r_nvec    <= n_vec;
        r_vec_cnt <= 8'd0;
        r_cnt     <= '0;
        r_lfsr    <= SEED;
      end
      case (r_state)
        ST_IDLE: begin
          r_dut_in <= ext_in;
          if (start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          r_dut_in  <= w_src;
          r_cnt     <= r_cnt + IN_W'(1);
          r_lfsr    <= w_lfsr_next;
          r_vec_cnt <= r_vec_cnt + 8'd1;
          if (w_last) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Leave once the final response is compacted on this edge.
          if (w_vld_next == '0) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  tt_bist_misr #(
    .SIG_W (SIG_W),
    .OUT_W (OUT_W),
    .POLY  (POLY)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_start_ok),
    .i_en   (w_cap),
    .i_data (dut_out),
    .i_mask (dut_oe),
    .o_sig  (signature)
  );

  assign dut_in = r_dut_in;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tt_bist_harness.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_bist_harness
// Description : Directed self-checking bench for tt_bist_harness with a
//               one-register loopback DUT (PIPE_LAT = 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_bist_harness;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        start;
  logic [1:0]  mode;
  logic [7:0]  n_vec;
  logic [7:0]  ext_in;
  logic [7:0]  dut_in;
  logic [7:0]  dut_out;
  logic [7:0]  dut_oe;
  logic [15:0] signature;
  logic        busy;
  logic        done;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  dut_log [0:299];
  int          nlog;

  always #5 clk = ~clk;

  tt_bist_harness dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .mode      (mode),
    .n_vec     (n_vec),
    .ext_in    (ext_in),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .dut_oe    (dut_oe),
    .signature (signature),
    .busy      (busy),
    .done      (done)
  );

  // Loopback user core with one register stage, gated by ena like the harness.
  always @(posedge clk) begin
    if (!rst_n)   dut_out <= 8'h00;
    else if (ena) dut_out <= dut_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_lfsr(input logic [15:0] v);
    return (v << 1) ^ (v[15] ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [15:0] m_sig(input logic [1:0] m, input int n, input logic [7:0] oe);
    logic [15:0] s;
    logic [15:0] l;
    logic [7:0]  c;
    logic [7:0]  v;
    s = 16'h0000;
    l = 16'hACE1;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      v = (m == 2'b01) ? c : l[7:0];
      s = m_lfsr(s) ^ {8'h00, v & oe};
      c = c + 8'd1;
      l = m_lfsr(l);
    end
    return s;
  endfunction

  task automatic run(input logic [1:0] m, input logic [7:0] nv, input int freeze_at,
                     input int disturb_at, output logic [15:0] sig_o, output int bcyc);
    int          guard;
    logic [7:0]  h_in;
    logic [15:0] h_sig;
    @(negedge clk);
    mode = m; n_vec = nv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("clear", 32'(signature), 32'h0);
    bcyc = 0; nlog = 0; guard = 0;
    while (busy && guard < 2000) begin
      start = 1'b0;
      if (nlog < 300) begin
        dut_log[nlog] = dut_in;
        nlog++;
      end
      bcyc++;
      if (bcyc == freeze_at) begin
        h_in  = dut_in;
        h_sig = signature;
        ena   = 1'b0;
        repeat (3) @(negedge clk);
        check("freeze", 32'({busy, dut_in, signature}), 32'({1'b1, h_in, h_sig}));
        ena = 1'b1;
      end
      if (bcyc == disturb_at) begin
        start = 1'b1;
        mode  = ~m;
        n_vec = nv + 8'd7;
      end
      @(negedge clk);
      guard++;
    end
    check("terminate", 32'(guard < 2000), 32'h1);
    check("done_flags", 32'({busy, done}), 32'h1);
    sig_o = signature;
  endtask

  initial begin
    logic [15:0] s_a, s_m, s_f, s_l, s_z, s_d, s_r;
    logic [15:0] l;
    int          b;
    int          guard;
    int          errs;

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; mode = 2'b00; n_vec = 8'd0;
    ext_in = 8'h5A; dut_oe = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_sig", 32'(signature), 32'h0);
    check("rst_dut_in", 32'(dut_in), 32'h0);
    rst_n = 1'b1;

    // Reset in the middle of a counter run.
    @(negedge clk);
    mode = 2'b01; n_vec = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (dut_in !== 8'd5 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("mid_reach", 32'(guard < 50), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'h0);
    check("mid_done", 32'(done), 32'h0);
    check("mid_sig", 32'(signature), 32'h0);
    check("mid_dut_in", 32'(dut_in), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two counter vectors through the loopback.
    run(2'b01, 8'd2, 0, 0, s_a, b);
    check("cnt2_v0", 32'(dut_log[1]), 32'h0);
    check("cnt2_v1", 32'(dut_log[2]), 32'h1);
    check("cnt2_sig", 32'(s_a), 32'h0001);
    check("cnt2_busy", 32'(b), 32'd4);

    // Masked vs full-mask compaction.
    dut_oe = 8'h0F;
    run(2'b01, 8'd32, 0, 0, s_m, b);
    check("mask_sig", 32'(s_m), 32'(m_sig(2'b01, 32, 8'h0F)));
    dut_oe = 8'hFF;
    run(2'b01, 8'd32, 0, 0, s_f, b);
    check("full_sig", 32'(s_f), 32'(m_sig(2'b01, 32, 8'hFF)));
    check("mask_differs", 32'(s_m != s_f), 32'h1);

    // LFSR, n_vec = 0 -> 256 vectors.
    run(2'b10, 8'd0, 0, 0, s_l, b);
    check("lfsr_first", 32'(dut_log[1]), 32'hE1);
    errs = 0;
    l = 16'hACE1;
    for (int k = 1; k <= 256; k++) begin
      if (dut_log[k] !== l[7:0]) errs++;
      l = m_lfsr(l);
    end
    check("lfsr_seq", 32'(errs), 32'h0);
    check("lfsr_busy", 32'(b), 32'd258);
    check("lfsr_sig", 32'(s_l), 32'(m_sig(2'b10, 256, 8'hFF)));

    // ena held low for 3 cycles mid-run.
    run(2'b01, 8'd32, 10, 0, s_z, b);
    check("freeze_sig", 32'(s_z), 32'(s_f));

    // start and mode/n_vec changes mid-run are ignored.
    run(2'b01, 8'd32, 0, 5, s_d, b);
    check("disturb_sig", 32'(s_d), 32'(s_f));
    check("disturb_busy", 32'(b), 32'd34);

    // Fresh run from DONE reproduces the signature.
    run(2'b01, 8'd32, 0, 0, s_r, b);
    check("rerun_sig", 32'(s_r), 32'(s_d));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
